keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the app's multiplexed 7-segment driver: drives a 4x4 matrix keypad one row at a time and reads the columns back.
- Debounces whole scan frames, detects single-key press events and presents them as an 8-bit status/code byte on a processor input port (e.g. i0 of rv32e_soc).
- A valid/ack handshake lets the processor consume each event exactly once.

Parameters:
- SCAN_TICKS, 120_000: clk cycles each row is driven (5 ms at 24 MHz); minimum 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-frame snapshots required before a snapshot is accepted; range 1..15.

Ports:
- clk  in  1  system clock, 24 MHz
- reset  in  1  synchronous, active-high
- col_in  in  4  keypad columns, active-low (external pull-ups); asynchronous
- row_out  out  4  keypad rows, active-low, one-hot-low
- key_ack  in  1  one-cycle pulse: consume current event
- key_status  out  8  {key_valid, overrun, 2'b00, key_code[3:0]}
- key_valid  out  1  same as key_status[7]
- key_held  out  1  1 while the accepted snapshot contains exactly one key

Behaviour:
- Synchronous active-high reset. Values after reset:
  - row_out = 4'b1110
  - tick counter = 0
  - snapshot and accepted state = 0
  - FSM = IDLE
  - key_status = 8'h00, key_valid = 0, key_held = 0
- col_in passes through a 2-flop synchronizer before use.
- Row scan:
  - Tick counter runs 0..SCAN_TICKS-1.
  - At tick SCAN_TICKS-1: sample ~col_sync into snapshot bits [row*4+3 : row*4], then rotate to the next row.
  - Row order 0,1,2,3, wrapping to 0. row_out[r] = 0 selects row r.
  - Frame = 4*SCAN_TICKS cycles.
- Frame end (sample of row 3):
  - Compare the new 16-bit snapshot with the previous frame's snapshot.
  - Equal: match_cnt increments, saturating at DEBOUNCE_FRAMES. Different: match_cnt = 1.
  - When match_cnt reaches DEBOUNCE_FRAMES, the snapshot becomes the accepted state. Evaluation uses the updated count in the same cycle.
- Key index = row*4 + col, range 0..15.
- FSM, evaluated only on the frame-end cycle after acceptance:
  - IDLE, accepted has exactly one bit set: emit event with that index, go to HELD.
  - IDLE, accepted has 2 or more bits set: go to BLOCKED, no event.
  - HELD, accepted = 0: go to IDLE.
  - HELD, any other value: stay in HELD. No auto-repeat; adding a second key does not generate an event.
  - BLOCKED: go to IDLE only when accepted = 0. No events while in BLOCKED.
- key_held = 1 only in HELD.
- Event emission, registered; key_status reflects the event the next cycle:
  - key_valid = 0: latch key_code, set key_valid = 1.
  - key_valid = 1: keep the old key_code, set overrun = 1, drop the new code.
- key_ack:
  - Clears key_valid and overrun. key_code is retained.
  - key_ack while key_valid = 0 has no effect.
  - Ack and event in the same cycle: ack applies first, then the new code is latched; key_valid = 1, overrun = 0.
- Reset mid-frame or mid-debounce: all state is discarded. Scanning restarts at row 0 with tick 0. A key held through reset is reported again after DEBOUNCE_FRAMES full frames.
- Worst-case event latency from a stable press: (DEBOUNCE_FRAMES+1) frames + 3 cycles.

Decomposition:
- Shared package constants:
  - KEY_ROWS = 4, KEY_COLS = 4
  - status bit positions STATUS_VALID = 7, STATUS_OVERRUN = 6
  - FSM state encoding IDLE/HELD/BLOCKED
  - the CLK_HZ constant (24_000_000) shared with the display driver
- One natural sub-module: frame_debouncer. It holds the snapshot comparison, match_cnt and the accepted register.
- Scan timing, FSM and handshake stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_TICKS=4 and DEBOUNCE_FRAMES=2, so one frame = 16 cycles. The keypad model drives col_in[c]=0 while row_out[r]=0 for each pressed key (r,c).
- Reset for 3 cycles, then release -> row_out=1110, key_status=8'h00. row_out is 1101 at cycle 4, 1011 at cycle 8, 0111 at cycle 12 and 1110 at cycle 16.
- Press (2,1) from frame start and hold -> key_status=8'h89 at the end of frame 2 (+1 cycle), key_held=1. Pulse key_ack -> 8'h09. Hold 5 more frames -> no new event.
- Release, then re-press (2,1) -> key_held falls after 2 frames. Second event gives 8'h89.
- Toggle key (0,0) every frame for 10 frames (bounce) -> key_valid stays 0, FSM stays IDLE.
- Press (0,3) and (1,0) together, then release (1,0) -> no event (BLOCKED); release all, then press (1,0) -> 8'h84.
- Overrun and simultaneity:
  - Press/release 3, no ack, then press/release 5 -> 8'hC3. key_ack -> 8'h03.
  - key_ack on the same cycle as a new event for key 7 -> 8'h87.
  - Assert reset mid-debounce -> 8'h00, row_out=1110.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Constants, state encoding and small helpers shared by the keypad scanner
// and its frame debouncer.
package keypad_scanner_pkg;

    localparam int KEY_ROWS       = 4;
    localparam int KEY_COLS       = 4;
    localparam int KEY_COUNT      = KEY_ROWS * KEY_COLS;
    localparam int STATUS_VALID   = 7;
    localparam int STATUS_OVERRUN = 6;
    localparam int CLK_HZ         = 24_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_BLOCKED = 2'd2
    } scan_state_t;

    function automatic logic [4:0] key_count(input logic [KEY_COUNT-1:0] keys);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            n = n + 5'(keys[i]);
        end
        return n;
    endfunction

    // Index of the highest set bit; only meaningful when exactly one key is down.
    function automatic logic [3:0] key_index(input logic [KEY_COUNT-1:0] keys);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (keys[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Processor-facing key event port: status byte, held flag and consume pulse.
interface keypad_scanner_if;
    logic       key_ack;
    logic [7:0] key_status;
    logic       key_valid;
    logic       key_held;

    modport master (output key_status, output key_valid, output key_held, input key_ack);
    modport slave  (input key_status, input key_valid, input key_held, output key_ack);
endinterface

// File: rtl/keypad_scanner_frame_debouncer.sv
// Assembles a 16-bit snapshot row by row and accepts it once it has been seen
// in DEBOUNCE_FRAMES consecutive frames.
module frame_debouncer
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sample,
    input  logic [1:0]           i_row,
    input  logic [KEY_COLS-1:0]  i_cols,
    output logic [KEY_COUNT-1:0] o_accepted,
    output logic                 o_frame_done
);

    localparam logic [3:0] MATCH_MAX = 4'(DEBOUNCE_FRAMES);

    logic [KEY_COUNT-1:0] r_snap;
    logic [KEY_COUNT-1:0] r_prev;
    logic [KEY_COUNT-1:0] r_accepted;
    logic [3:0]           r_match_cnt;
    logic                 r_frame_done;
    logic [KEY_COUNT-1:0] w_snap_next;
    logic [3:0]           w_cnt_next;
    logic                 w_frame_end;

    generate
        for (genvar gi = 0; gi < KEY_ROWS; gi++) begin : g_row
            assign w_snap_next[gi*KEY_COLS +: KEY_COLS] =
                (i_sample && i_row == 2'(gi)) ? i_cols : r_snap[gi*KEY_COLS +: KEY_COLS];
        end
    endgenerate

    assign w_frame_end = i_sample && (i_row == 2'(KEY_ROWS - 1));

    always_comb begin
        w_cnt_next = 4'd1;
        if (w_snap_next == r_prev) begin
            w_cnt_next = (r_match_cnt >= MATCH_MAX) ? MATCH_MAX : r_match_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap       <= '0;
            r_prev       <= '0;
            r_accepted   <= '0;
            r_match_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_snap       <= w_snap_next;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_prev      <= w_snap_next;
                r_match_cnt <= w_cnt_next;
                if (w_cnt_next == MATCH_MAX) begin
                    r_accepted <= w_snap_next;
                end
            end
        end
    end

    assign o_accepted   = r_accepted;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sampling, single-key event
// FSM and a valid/ack status byte for the processor.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_TICKS      = 120_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_COLS-1:0] col_in,
    output logic [KEY_ROWS-1:0] row_out,
    keypad_scanner_if.master    key_if
);

    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);

    logic [KEY_COLS-1:0]  r_col_meta;
    logic [KEY_COLS-1:0]  r_col_sync;
    logic [TICK_W-1:0]    r_tick;
    logic [1:0]           r_row;
    scan_state_t          r_state;
    logic                 r_valid;
    logic                 r_overrun;
    logic [3:0]           r_code;
    scan_state_t          w_state_next;
    logic                 w_sample;
    logic                 w_frame_done;
    logic [KEY_COUNT-1:0] w_accepted;
    logic [4:0]           w_key_count;
    logic                 w_emit;
    logic [3:0]           w_emit_code;
    logic [7:0]           w_status;

    // Columns idle high through pull-ups, so the synchronizer resets to "no key".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            r_col_meta <= col_in;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_sample = (r_tick == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= '0;
            r_row  <= '0;
        end else if (w_sample) begin
            r_tick <= '0;
            r_row  <= r_row + 2'd1;
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < KEY_ROWS; gi++) begin : g_row_drv
            assign row_out[gi] = (r_row != 2'(gi));
        end
    endgenerate

    frame_debouncer #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debouncer (
        .clk          (clk),
        .reset        (reset),
        .i_sample     (w_sample),
        .i_row        (r_row),
        .i_cols       (~r_col_sync),
        .o_accepted   (w_accepted),
        .o_frame_done (w_frame_done)
    );

    assign w_key_count = key_count(w_accepted);

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_emit_code  = '0;
        if (w_frame_done) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_key_count == 5'd1) begin
                        w_emit       = 1'b1;
                        w_emit_code  = key_index(w_accepted);
                        w_state_next = ST_HELD;
                    end else if (w_key_count >= 5'd2) begin
                        w_state_next = ST_BLOCKED;
                    end
                end
                ST_HELD, ST_BLOCKED: begin
                    if (w_accepted == '0) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An ack in the same cycle as an event frees the slot before the new code lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_code    <= '0;
        end else begin
            if (key_if.key_ack) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_emit) begin
                if (!r_valid || key_if.key_ack) begin
                    r_code    <= w_emit_code;
                    r_valid   <= 1'b1;
                    r_overrun <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STATUS_VALID]   = r_valid;
        w_status[STATUS_OVERRUN] = r_overrun;
        w_status[3:0]            = r_code;
    end

    assign key_if.key_status = w_status;
    assign key_if.key_valid  = r_valid;
    assign key_if.key_held   = (r_state == ST_HELD);

endmodule
